adc_scan_sequencer: RTL and testbench

//  Timing controller for the external 8-bit parallel ADC and the 8:1 phototransistor mux. Steps through
//  the channels in order: drives the mux address, waits for the mux to settle, pulses ADC start, waits
//  for the conversion, then latches the result. Delivers one sample per channel and a min-per-frame

---
 rtl/adc_scan_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_sequencer
// Description : Scans an 8:1 phototransistor mux into an external parallel ADC,
//               producing per-channel samples and a per-frame minimum summary.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_sequencer #(
    parameter int NUM_CH       = 8,
    parameter int CH_W         = 3,
    parameter int TICK_DIV     = 1250,
    parameter int SETTLE_TICKS = 1,
    parameter int START_TICKS  = 2,
    parameter int CONV_TICKS   = 4,
    parameter int USE_EOC      = 0,
    parameter int EOC_TIMEOUT  = 16,
    parameter int THRESH       = 100
) (
    input  logic            CLK100MHZ,
    input  logic            reset,
    input  logic            enable,
    input  logic [7:0]      adc_data,
    input  logic            adc_eoc,
    output logic [CH_W-1:0] mux_addr,
    output logic            adc_start,
    output logic            sample_valid,
    output logic [CH_W-1:0] sample_ch,
    output logic [7:0]      sample_data,
    output logic            eoc_timeout,
    output logic            frame_done,
    output logic [7:0]      min_val,
    output logic [CH_W-1:0] min_addr,
    output logic            below_thresh
);

    localparam int DIV_W  = $clog2(TICK_DIV);
    localparam int TCNT_W = 16;

    localparam logic [DIV_W-1:0]  c_div_last    = DIV_W'(TICK_DIV - 1);
    localparam logic [TCNT_W-1:0] c_settle_last = TCNT_W'(SETTLE_TICKS - 1);
    localparam logic [TCNT_W-1:0] c_start_last  = TCNT_W'(START_TICKS - 1);
    localparam logic [TCNT_W-1:0] c_conv_last   = TCNT_W'(CONV_TICKS - 1);
    localparam logic [TCNT_W-1:0] c_to_last     = TCNT_W'(EOC_TIMEOUT - 1);
    localparam logic [CH_W-1:0]   c_last_ch     = CH_W'(NUM_CH - 1);
    localparam logic [7:0]        c_thresh      = 8'(THRESH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_START   = 3'd2,
        S_CONVERT = 3'd3,
        S_LATCH   = 3'd4,
        S_FRAME   = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DIV_W-1:0]  r_div;
    logic [TCNT_W-1:0] r_tcnt;
    logic              w_tick;
    logic              w_eoc_to;
    logic [7:0]        w_sample;
    logic [CH_W-1:0]   r_ch;
    logic              r_eoc_s1;
    logic              r_eoc_s2;
    logic              r_timed_out;
    logic              r_adc_start;
    logic              r_sample_valid;
    logic [CH_W-1:0]   r_sample_ch;
    logic [7:0]        r_sample_data;
    logic              r_eoc_timeout;
    logic              r_frame_done;
    logic [7:0]        r_run_min;
    logic [CH_W-1:0]   r_run_addr;
    logic [7:0]        r_min_val;
    logic [CH_W-1:0]   r_min_addr;
    logic              r_below;

    assign w_tick   = (r_div == c_div_last);
    assign w_sample = r_timed_out ? 8'hFF : adc_data;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_eoc_to = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (w_tick && (r_tcnt == c_settle_last)) w_next = S_START;
            end
            S_START: begin
                if (w_tick && (r_tcnt == c_start_last)) w_next = S_CONVERT;
            end
            S_CONVERT: begin
                if (USE_EOC != 0) begin
                    if (r_eoc_s2) begin
                        w_next = S_LATCH;
                    end else if (w_tick && (r_tcnt == c_to_last)) begin
                        w_next   = S_LATCH;
                        w_eoc_to = 1'b1;
                    end
                end else if (w_tick && (r_tcnt == c_conv_last)) begin
                    w_next = S_LATCH;
                end
            end
            S_LATCH: begin
                w_next = (r_ch == c_last_ch) ? S_FRAME : S_SETTLE;
            end
            S_FRAME: begin
                w_next = enable ? S_SETTLE : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_div          <= '0;
            r_tcnt         <= '0;
            r_ch           <= '0;
            r_eoc_s1       <= 1'b0;
            r_eoc_s2       <= 1'b0;
            r_timed_out    <= 1'b0;
            r_adc_start    <= 1'b0;
            r_sample_valid <= 1'b0;
            r_sample_ch    <= '0;
            r_sample_data  <= 8'h00;
            r_eoc_timeout  <= 1'b0;
            r_frame_done   <= 1'b0;
            r_run_min      <= 8'hFF;
            r_run_addr     <= '0;
            r_min_val      <= 8'hFF;
            r_min_addr     <= '0;
            r_below        <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_eoc_timeout  <= 1'b0;
            r_frame_done   <= 1'b0;
            r_eoc_s1       <= adc_eoc;
            r_eoc_s2       <= r_eoc_s1;
            // Registered from the next state so the strobe is high exactly while in START.
            r_adc_start    <= (w_next == S_START);

            if (w_next != r_state) begin
                r_div  <= '0;
                r_tcnt <= '0;
            end else if (w_tick) begin
                r_div  <= '0;
                r_tcnt <= r_tcnt + 1'b1;
            end else begin
                r_div  <= r_div + 1'b1;
            end

            if ((r_state == S_CONVERT) && (w_next == S_LATCH)) begin
                r_timed_out <= w_eoc_to;
            end

            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_ch       <= '0;
                        r_run_min  <= 8'hFF;
                        r_run_addr <= '0;
                    end
                end
                S_LATCH: begin
                    r_sample_data  <= w_sample;
                    r_sample_ch    <= r_ch;
                    r_sample_valid <= 1'b1;
                    r_eoc_timeout  <= r_timed_out;
                    // Strict compare keeps the lowest channel index on ties.
                    if (w_sample < r_run_min) begin
                        r_run_min  <= w_sample;
                        r_run_addr <= r_ch;
                    end
                    if (r_ch != c_last_ch) r_ch <= r_ch + 1'b1;
                end
                S_FRAME: begin
                    r_min_val    <= r_run_min;
                    r_min_addr   <= r_run_addr;
                    r_below      <= (r_run_min < c_thresh);
                    r_frame_done <= 1'b1;
                    if (enable) begin
                        r_ch       <= '0;
                        r_run_min  <= 8'hFF;
                        r_run_addr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mux_addr     = r_ch;
    assign adc_start    = r_adc_start;
    assign sample_valid = r_sample_valid;
    assign sample_ch    = r_sample_ch;
    assign sample_data  = r_sample_data;
    assign eoc_timeout  = r_eoc_timeout;
    assign frame_done   = r_frame_done;
    assign min_val      = r_min_val;
    assign min_addr     = r_min_addr;
    assign below_thresh = r_below;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_scan_sequencer
// Description : Scoreboard bench for adc_scan_sequencer (timer mode and EOC mode).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_sequencer;

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] d;
        logic       to;
    } samp_t;

    typedef struct packed {
        logic [7:0] v;
        logic [2:0] a;
        logic       b;
    } frm_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Timer-mode DUT
    logic       reset, enable, adc_eoc;
    logic [7:0] adc_data;
    logic [2:0] mux_addr, sample_ch, min_addr;
    logic       adc_start, sample_valid, eoc_timeout, frame_done, below_thresh;
    logic [7:0] sample_data, min_val;
    logic [7:0] tbl [8];
    assign adc_data = tbl[mux_addr];

    // EOC-mode DUT
    logic       reset_e, enable_e, eoc_e;
    logic [7:0] adc_data_e;
    logic [2:0] mux_addr_e, sample_ch_e, min_addr_e;
    logic       adc_start_e, sample_valid_e, eoc_timeout_e, frame_done_e, below_thresh_e;
    logic [7:0] sample_data_e, min_val_e;
    logic [7:0] tble [8];
    assign adc_data_e = tble[mux_addr_e];

    adc_scan_sequencer #(
        .NUM_CH(8), .CH_W(3), .TICK_DIV(4), .SETTLE_TICKS(1), .START_TICKS(2),
        .CONV_TICKS(4), .USE_EOC(0), .EOC_TIMEOUT(16), .THRESH(100)
    ) dut (
        .CLK100MHZ(clk), .reset(reset), .enable(enable), .adc_data(adc_data),
        .adc_eoc(adc_eoc), .mux_addr(mux_addr), .adc_start(adc_start),
        .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
        .eoc_timeout(eoc_timeout), .frame_done(frame_done), .min_val(min_val),
        .min_addr(min_addr), .below_thresh(below_thresh)
    );

    adc_scan_sequencer #(
        .NUM_CH(8), .CH_W(3), .TICK_DIV(4), .SETTLE_TICKS(1), .START_TICKS(2),
        .CONV_TICKS(4), .USE_EOC(1), .EOC_TIMEOUT(16), .THRESH(100)
    ) dut_e (
        .CLK100MHZ(clk), .reset(reset_e), .enable(enable_e), .adc_data(adc_data_e),
        .adc_eoc(eoc_e), .mux_addr(mux_addr_e), .adc_start(adc_start_e),
        .sample_valid(sample_valid_e), .sample_ch(sample_ch_e), .sample_data(sample_data_e),
        .eoc_timeout(eoc_timeout_e), .frame_done(frame_done_e), .min_val(min_val_e),
        .min_addr(min_addr_e), .below_thresh(below_thresh_e)
    );

    samp_t sq[$];
    frm_t  fq[$];
    samp_t sqe[$];
    frm_t  fqe[$];
    logic [7:0] exp_min_out = 8'hFF;
    bit e_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bad(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event occurred that the bench did not require (t=%0t)", name, $time);
    endtask

    // ---------------- timer-mode monitor ----------------
    int st_run = 0;
    int last_sv = 0;
    always @(negedge clk) begin
        samp_t s;
        frm_t  f;
        if (reset) begin
            st_run = 0;
        end else begin
            if (adc_start) st_run++;
            else if (st_run != 0) begin
                chk("adc_start_width", st_run, 8);
                st_run = 0;
            end
            if (sample_valid) begin
                if (sq.size() == 0) bad("sample_unexpected");
                else begin
                    s = sq.pop_front();
                    chk("sample_ch", {29'd0, sample_ch}, {29'd0, s.ch});
                    chk("sample_data", {24'd0, sample_data}, {24'd0, s.d});
                end
                chk("eoc_timeout_timer", {31'd0, eoc_timeout}, 32'd0);
                chk("min_val_hold", {24'd0, min_val}, {24'd0, exp_min_out});
                if (sample_ch != 3'd0) chk("sample_gap", cyc - last_sv, 29);
                last_sv = cyc;
            end
            if (frame_done) begin
                chk("frame_after_ch7", cyc - last_sv, 1);
                if (fq.size() == 0) bad("frame_unexpected");
                else begin
                    f = fq.pop_front();
                    chk("min_val", {24'd0, min_val}, {24'd0, f.v});
                    chk("min_addr", {29'd0, min_addr}, {29'd0, f.a});
                    chk("below_thresh", {31'd0, below_thresh}, {31'd0, f.b});
                    exp_min_out = f.v;
                end
            end
        end
    end

    // ---------------- EOC-mode monitor ----------------
    always @(negedge clk) begin
        samp_t s;
        frm_t  f;
        if (!reset_e && sample_valid_e) begin
            if (sqe.size() == 0) bad("eoc_sample_unexpected");
            else begin
                s = sqe.pop_front();
                chk("eoc_sample_ch", {29'd0, sample_ch_e}, {29'd0, s.ch});
                chk("eoc_sample_data", {24'd0, sample_data_e}, {24'd0, s.d});
                chk("eoc_timeout_flag", {31'd0, eoc_timeout_e}, {31'd0, s.to});
            end
        end
        if (!reset_e && frame_done_e) begin
            if (fqe.size() == 0) bad("eoc_frame_unexpected");
            else begin
                f = fqe.pop_front();
                chk("eoc_min_val", {24'd0, min_val_e}, {24'd0, f.v});
                chk("eoc_min_addr", {29'd0, min_addr_e}, {29'd0, f.a});
                chk("eoc_below_thresh", {31'd0, below_thresh_e}, {31'd0, f.b});
            end
        end
    end

    task automatic wait_frame(input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < max);
        if (!frame_done) bad("frame_done_timeout");
    endtask

    task automatic wait_sample(input logic [2:0] ch, input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sample_valid && sample_ch == ch) && n < max);
        if (!(sample_valid && sample_ch == ch)) bad("sample_wait_timeout");
    endtask

    task automatic push_tbl_samples();
        for (int i = 0; i < 8; i++) sq.push_back('{ch: 3'(i), d: tbl[i], to: 1'b0});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_adc_start"}, {31'd0, adc_start}, 32'd0);
        chk({tag, "_mux_addr"}, {29'd0, mux_addr}, 32'd0);
        chk({tag, "_sample_valid"}, {31'd0, sample_valid}, 32'd0);
        chk({tag, "_sample_ch"}, {29'd0, sample_ch}, 32'd0);
        chk({tag, "_sample_data"}, {24'd0, sample_data}, 32'd0);
        chk({tag, "_eoc_timeout"}, {31'd0, eoc_timeout}, 32'd0);
        chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        chk({tag, "_min_val"}, {24'd0, min_val}, 32'h0000_00FF);
        chk({tag, "_min_addr"}, {29'd0, min_addr}, 32'd0);
        chk({tag, "_below_thresh"}, {31'd0, below_thresh}, 32'd0);
    endtask

    // ---------------- timer-mode stimulus ----------------
    initial begin
        int n;
        reset = 1'b1; enable = 1'b0; adc_eoc = 1'b0;
        for (int i = 0; i < 8; i++) tbl[i] = 8'(20 * (i + 1));
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        reset = 1'b0;

        // Frame A: 20,40..160 -> min 20 @ ch0
        push_tbl_samples();
        fq.push_back('{v: 8'd20, a: 3'd0, b: 1'b1});
        enable = 1'b1;
        wait_frame(400);

        // Frame B: ch2 = ch5 = 50 -> tie keeps ch2
        for (int i = 0; i < 8; i++) tbl[i] = (i == 2 || i == 5) ? 8'd50 : 8'd200;
        push_tbl_samples();
        fq.push_back('{v: 8'd50, a: 3'd2, b: 1'b1});
        wait_frame(400);

        // Frame C: all 150, enable dropped during ch3 CONVERT
        for (int i = 0; i < 8; i++) tbl[i] = 8'd150;
        push_tbl_samples();
        fq.push_back('{v: 8'd150, a: 3'd0, b: 1'b0});
        wait_sample(3'd2, 400);
        repeat (15) @(negedge clk);
        enable = 1'b0;
        wait_frame(400);
        n = 0;
        repeat (150) begin
            @(negedge clk);
            if (adc_start) n++;
        end
        chk("idle_no_adc_start", n, 0);

        // Reset during START of ch4, then restart at ch0
        for (int i = 0; i < 8; i++) tbl[i] = 8'(200 - 10 * i);
        for (int i = 0; i < 4; i++) sq.push_back('{ch: 3'(i), d: tbl[i], to: 1'b0});
        enable = 1'b1;
        wait_sample(3'd3, 400);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!adc_start && n < 40);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        chk("pre_reset_adc_start", {31'd0, adc_start}, 32'd1);
        chk("pre_reset_mux_addr", {29'd0, mux_addr}, 32'd4);
        #1 reset = 1'b1;
        #1;
        chk_reset_outputs("async");
        exp_min_out = 8'hFF;
        @(posedge clk);
        #2 reset = 1'b0;
        push_tbl_samples();
        fq.push_back('{v: 8'd130, a: 3'd7, b: 1'b0});
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_frame(400);
        repeat (20) @(negedge clk);

        n = 0;
        while (!e_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!e_done) bad("eoc_sequence_timeout");
        chk("samples_pending", sq.size(), 0);
        chk("frames_pending", fq.size(), 0);
        chk("eoc_samples_pending", sqe.size(), 0);
        chk("eoc_frames_pending", fqe.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    // ---------------- EOC-mode stimulus ----------------
    initial begin
        int k;
        int n;
        reset_e = 1'b1; enable_e = 1'b0; eoc_e = 1'b0;
        for (int i = 0; i < 8; i++) tble[i] = 8'(10 * (i + 3));
        repeat (3) @(negedge clk);
        reset_e = 1'b0;
        for (int i = 0; i < 8; i++)
            sqe.push_back('{ch: 3'(i), d: (i == 1) ? 8'hFF : tble[i], to: (i == 1)});
        fqe.push_back('{v: 8'd30, a: 3'd0, b: 1'b1});
        enable_e = 1'b1;
        for (int ch = 0; ch < 8; ch++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!adc_start_e && n < 100);
            do begin
                @(negedge clk);
                n++;
            end while (adc_start_e && n < 100);
            if (n >= 100) bad("eoc_start_timeout");
            // k counts clocks into CONVERT; k=0 is its first cycle
            k = 0;
            while (!sample_valid_e && k < 200) begin
                @(negedge clk);
                k++;
                if (ch == 0 && k == 12) eoc_e = 1'b1;
                if (ch >= 2 && k == 4) eoc_e = 1'b1;
            end
            if (ch == 0) begin
                enable_e = 1'b0;
                n_cmp++;
                if (k < 15 || k > 16) begin
                    n_err++;
                    $display("FAIL eoc_latency: got %0d clocks, required 15..16", k);
                end
            end
            if (ch == 1) chk("eoc_timeout_latency", k, 65);
            eoc_e = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done_e && n < 10);
        repeat (5) @(negedge clk);
        e_done = 1'b1;
    end

endmodule
`default_nettype wire
